pwm_capture_mc: RTL and testbench

Multi-channel PWM period/duty capture block, the parametrised successor to the single-input PWM temperature-sensor front end in `tt_um_uart_temp_sens`. Each of `NUM_CH` asynchronous PWM inputs is synchronised and its high and low phase lengths are measured in `clk` cycles. On every completed period the block posts one record per channel. Records are merged round-robin onto a single valid/ready stream, which feeds the UART formatter downstream.

---
 rtl/pwm_capture_mc.sv | 171 +++++++++++++++++
 tb/tb_pwm_capture_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM high/low phase capture; one record per completed period,
// merged round-robin onto a single valid/ready stream.
module pwm_capture_mc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] pwm_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [CNT_W-1:0]  m_high,
    output logic [CNT_W-1:0]  m_low,
    output logic [2:0]        m_flags
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] drain_c;
    logic [CNT_W-1:0]  slot_high  [NUM_CH];
    logic [CNT_W-1:0]  slot_low   [NUM_CH];
    logic [2:0]        slot_flags [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic              out_free_c;
    logic              grant_vld_c;
    logic [CH_W-1:0]   grant_c;

    assign out_free_c = !m_valid || m_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   s_d;
        logic                   rise;
        logic                   fall;
        state_t                 state_q;
        logic [CNT_W-1:0]       high_cnt;
        logic [CNT_W-1:0]       low_cnt;
        logic                   sat_h;
        logic                   sat_l;
        logic                   pend_q;
        logic [CNT_W-1:0]       slot_high_q;
        logic [CNT_W-1:0]       slot_low_q;
        logic [2:0]             slot_flags_q;

        assign s             = sync_q[SYNC_STAGES-1];
        assign rise          = s & ~s_d;
        assign fall          = ~s & s_d;
        assign drain_c[c]    = out_free_c && grant_vld_c && (grant_c == CH_W'(c));
        assign pend[c]       = pend_q;
        assign slot_high[c]  = slot_high_q;
        assign slot_low[c]   = slot_low_q;
        assign slot_flags[c] = slot_flags_q;

        // Synchroniser keeps running regardless of en.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                s_d    <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i[c]};
                s_d    <= s;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= ST_IDLE;
                high_cnt     <= '0;
                low_cnt      <= '0;
                sat_h        <= 1'b0;
                sat_l        <= 1'b0;
                pend_q       <= 1'b0;
                slot_high_q  <= '0;
                slot_low_q   <= '0;
                slot_flags_q <= '0;
            end else if (!en) begin
                state_q <= ST_IDLE;
                sat_h   <= 1'b0;
                sat_l   <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                if (drain_c[c]) pend_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            high_cnt <= CNT_ONE;
                            sat_h    <= 1'b0;
                            sat_l    <= 1'b0;
                            state_q  <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            low_cnt <= CNT_ONE;
                            state_q <= ST_LOW;
                        end else if (s) begin
                            if (high_cnt == CNT_MAX) sat_h <= 1'b1;
                            else                     high_cnt <= high_cnt + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        // A capture overrides a same-cycle drain; overrun only if the slot is not leaving.
                        if (rise) begin
                            slot_high_q  <= high_cnt;
                            slot_low_q   <= low_cnt;
                            slot_flags_q <= {pend_q & ~drain_c[c], sat_l, sat_h};
                            pend_q       <= 1'b1;
                            high_cnt     <= CNT_ONE;
                            sat_h        <= 1'b0;
                            sat_l        <= 1'b0;
                            state_q      <= ST_HIGH;
                        end else if (!s) begin
                            if (low_cnt == CNT_MAX) sat_l <= 1'b1;
                            else                    low_cnt <= low_cnt + CNT_ONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Round-robin search for the first pending channel starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        grant_vld_c = 1'b0;
        grant_c     = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld_c && pend[CH_W'(idx)]) begin
                grant_vld_c = 1'b1;
                grant_c     = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_high  <= '0;
            m_low   <= '0;
            m_flags <= '0;
            rr_ptr  <= '0;
        end else if (out_free_c) begin
            m_valid <= grant_vld_c;
            if (grant_vld_c) begin
                m_ch    <= grant_c;
                m_high  <= slot_high[grant_c];
                m_low   <= slot_low[grant_c];
                m_flags <= slot_flags[grant_c];
                rr_ptr  <= (32'(grant_c) == NUM_CH - 1) ? '0 : grant_c + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture_mc.sv
// Self-checking bench for pwm_capture_mc: table vectors, randomized periods
// against a run-length reference model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_pwm_capture_mc;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 11;
    localparam int SYNC   = 2;
    localparam int MAXV   = (1 << CNT_W) - 1;

    typedef struct {
        int ch;
        int hi;
        int lo;
        int fl;
        int cyc;
    } rec_t;

    typedef struct {
        int h;
        int l;
        int eh;
        int el;
        int ef;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NUM_CH-1:0] pwm;
    logic              m_valid;
    logic              m_ready;
    logic [1:0]        m_ch;
    logic [CNT_W-1:0]  m_high;
    logic [CNT_W-1:0]  m_low;
    logic [2:0]        m_flags;

    pwm_capture_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pwm_i   (pwm),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch),
        .m_high  (m_high),
        .m_low   (m_low),
        .m_flags (m_flags)
    );

    int   errors;
    int   checks;
    int   cyc;
    bit   rand_ready;
    rec_t obs_q[$];
    rec_t exp_q[$];
    bit   have_prev [NUM_CH];
    int   prev_h    [NUM_CH];
    int   prev_l    [NUM_CH];
    vec_t tbl       [7];
    int   rr_ch     [9];
    int   rr_lo     [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every accepted record with the cycle it was accepted in.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready)
            obs_q.push_back('{int'(m_ch), int'(m_high), int'(m_low), int'(m_flags), cyc});
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = ($urandom_range(3) != 0);
        end
    endtask

    // Reference: a record reports the previous full period of the channel, clipped to the counter range.
    function automatic rec_t model_rec(input int ch, input int h, input int l);
        rec_t r;
        r.ch  = ch;
        r.hi  = (h > MAXV) ? MAXV : h;
        r.lo  = (l > MAXV) ? MAXV : l;
        r.fl  = ((h > MAXV) ? 1 : 0) + ((l > MAXV) ? 2 : 0);
        r.cyc = 0;
        return r;
    endfunction

    task automatic model_start(input int ch, input int h, input int l);
        if (have_prev[ch]) exp_q.push_back(model_rec(ch, prev_h[ch], prev_l[ch]));
        have_prev[ch] = 1'b1;
        prev_h[ch]    = h;
        prev_l[ch]    = l;
    endtask

    task automatic drive_period(input logic [1:0] ch, input int h, input int l);
        model_start(int'(ch), h, l);
        pwm[ch] = 1'b1;
        tick(h);
        pwm[ch] = 1'b0;
        tick(l);
    endtask

    task automatic do_reset();
        pwm   = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) have_prev[i] = 1'b0;
    endtask

    task automatic compare_queues(input string name);
        check({name, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({name, " ch"},    32'(obs_q[i].ch), 32'(exp_q[i].ch));
            check({name, " high"},  32'(obs_q[i].hi), 32'(exp_q[i].hi));
            check({name, " low"},   32'(obs_q[i].lo), 32'(exp_q[i].lo));
            check({name, " flags"}, 32'(obs_q[i].fl), 32'(exp_q[i].fl));
        end
    endtask

    initial begin
        int k;
        int lt;
        tbl[0] = '{25,   100,  25,   100,  0};
        tbl[1] = '{25,   3000, 25,   2047, 2};
        tbl[2] = '{25,   100,  25,   100,  0};
        tbl[3] = '{2100, 40,   2047, 40,   1};
        tbl[4] = '{1,    1,    1,    1,    0};
        tbl[5] = '{3,    2047, 3,    2047, 0};
        tbl[6] = '{2048, 2048, 2047, 2047, 3};
        rr_ch  = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
        rr_lo  = '{10, 10, 10, 10, 10, 25, 25, 25, 10};

        rst_n = 1'b0; en = 1'b0; pwm = '0; m_ready = 1'b0; rand_ready = 1'b0;
        tick(3);
        check("reset m_valid", 32'(m_valid), 0);
        check("reset m_ch",    32'(m_ch),    0);
        check("reset m_high",  32'(m_high),  0);
        check("reset m_low",   32'(m_low),   0);
        check("reset m_flags", 32'(m_flags), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick(2);

        // Basic period on ch0 with record latency.
        do_reset();
        m_ready = 1'b1;
        drive_period(2'd0, 25, 100);
        check("basic first period", 32'(obs_q.size()), 0);
        model_start(0, 25, 100);
        pwm[0] = 1'b1;
        k = 0;
        while (m_valid !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("basic latency", 32'(k), 32'(SYNC + 2));
        tick(25 - k);
        pwm[0] = 1'b0;
        tick(100);
        drive_period(2'd0, 25, 100);
        drive_period(2'd0, 2, 12);
        compare_queues("basic");

        // Table vectors on ch3, including saturation and minimum phases.
        do_reset();
        m_ready = 1'b1;
        foreach (tbl[i]) drive_period(2'd3, tbl[i].h, tbl[i].l);
        drive_period(2'd3, 2, 12);
        check("table count", 32'(obs_q.size()), 32'($size(tbl)));
        for (int i = 0; i < $size(tbl) && i < obs_q.size(); i++) begin
            check("table ch",    32'(obs_q[i].ch), 3);
            check("table high",  32'(obs_q[i].hi), 32'(tbl[i].eh));
            check("table low",   32'(obs_q[i].lo), 32'(tbl[i].el));
            check("table flags", 32'(obs_q[i].fl), 32'(tbl[i].ef));
        end

        // Random low phases on ch1 with random backpressure.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            lt = (i == 0) ? 2047 : (i == 1) ? 1 : int'($urandom_range(2047, 1));
            drive_period(2'd1, 25, lt);
        end
        drive_period(2'd1, 2, 12);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        tick(12);
        compare_queues("random");

        // Overrun: three ch2 periods while stalled.
        do_reset();
        m_ready = 1'b0;
        drive_period(2'd2, 10, 20);
        drive_period(2'd2, 11, 21);
        drive_period(2'd2, 12, 22);
        pwm[2] = 1'b1;
        tick(8);
        check("stall m_valid", 32'(m_valid), 1);
        check("stall m_ch",    32'(m_ch),    2);
        check("stall m_high",  32'(m_high),  10);
        check("stall m_low",   32'(m_low),   20);
        check("stall m_flags", 32'(m_flags), 0);
        check("stall no transfer", 32'(obs_q.size()), 0);
        m_ready = 1'b1;
        pwm[2]  = 1'b0;
        tick(10);
        exp_q.delete();
        exp_q.push_back('{2, 10, 20, 0, 0});
        exp_q.push_back('{2, 12, 22, 4, 0});
        compare_queues("overrun");

        // Round-robin with all channels capturing together, then from rr_ptr=2.
        do_reset();
        m_ready = 1'b1;
        pwm = 4'hF; tick(5); pwm = 4'h0; tick(10);
        pwm = 4'hF; tick(5); pwm = 4'h0; tick(10);
        pwm = 4'h2; tick(5); pwm = 4'h0; tick(10);
        pwm = 4'hF; tick(5); pwm = 4'h0; tick(10);
        check("rr count", 32'(obs_q.size()), 9);
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            check("rr ch",   32'(obs_q[i].ch), 32'(rr_ch[i]));
            check("rr high", 32'(obs_q[i].hi), 5);
            check("rr low",  32'(obs_q[i].lo), 32'(rr_lo[i]));
            if (i != 0 && i != 4 && i != 5)
                check("rr back-to-back", 32'(obs_q[i].cyc - obs_q[i-1].cyc), 1);
        end

        // Disable while a record is stalled.
        do_reset();
        m_ready = 1'b0;
        pwm = 4'h9; tick(5); pwm = 4'h0; tick(10);
        pwm = 4'h9; tick(4);
        en = 1'b0;
        tick(3);
        m_ready = 1'b1;
        tick(3);
        pwm = 4'h0; tick(10); pwm = 4'h9; tick(5); pwm = 4'h0; tick(10);
        pwm = 4'h9; tick(5); pwm = 4'h0; tick(10);
        exp_q.delete();
        exp_q.push_back('{0, 5, 10, 0, 0});
        compare_queues("disable");
        en = 1'b1;

        // Reset in the middle of a low phase.
        do_reset();
        m_ready = 1'b0;
        pwm[0] = 1'b1; tick(5); pwm[0] = 1'b0; tick(10);
        pwm[0] = 1'b1; tick(6);
        check("pre-reset m_valid", 32'(m_valid), 1);
        pwm[0] = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("async reset m_valid", 32'(m_valid), 0);
        check("async reset m_high",  32'(m_high),  0);
        check("async reset m_low",   32'(m_low),   0);
        tick(2);
        rst_n = 1'b1;
        obs_q.delete();
        m_ready = 1'b1;
        tick(3);
        pwm[0] = 1'b1; tick(5); pwm[0] = 1'b0; tick(10);
        check("post-reset first period", 32'(obs_q.size()), 0);
        pwm[0] = 1'b1; tick(2); pwm[0] = 1'b0; tick(10);
        exp_q.delete();
        exp_q.push_back('{0, 5, 10, 0, 0});
        compare_queues("post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
